// File: rtl/spi_pixel_loader_if.sv
// spi_pixel_loader_if: SPI pad inputs and pixel-store/controller outputs of spi_pixel_loader
// master drives sclk/mosi/ss_n/load_ack and observes the loader outputs; slave is the loader.
// spi_in is [0:7] with bit 0 the first-received (most significant) bit.
interface spi_pixel_loader_if;
  logic       sclk;
  logic       mosi;
  logic       ss_n;
  logic       load_ack;
  logic [0:7] spi_in;
  logic       write_en;
  logic       shift_SPI;
  logic       image_ready;
  logic       frame_err;
  logic [6:0] byte_cnt;
  modport master (
    output sclk, mosi, ss_n, load_ack,
    input  spi_in, write_en, shift_SPI, image_ready, frame_err, byte_cnt
  );
  modport slave (
    input  sclk, mosi, ss_n, load_ack,
    output spi_in, write_en, shift_SPI, image_ready, frame_err, byte_cnt
  );
endinterface

// File: rtl/spi_pixel_loader.sv
// spi_pixel_loader: SPI mode-0 byte deserialiser feeding the 72-byte pixel store
// Ports: clk, rst (sync, active high); bus (slave modport):
//   sclk/mosi/ss_n  asynchronous SPI pads, MSB first, ss_n active low
//   load_ack        controller took the image, clears image_ready
//   spi_in          completed byte, held until the next byte completes
//   write_en/shift_SPI  one-cycle store strobes per written byte
//   image_ready/frame_err/byte_cnt  frame status
// Define CHECKSUM_EN to expect a trailing mod-256 checksum byte after the pixels.
module spi_pixel_loader #(
  parameter int NUM_BYTES   = 72,
  parameter int SYNC_STAGES = 2
) (
  input logic               clk,
  input logic               rst,
  spi_pixel_loader_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE, RECV, WRITE, DONE
`ifdef CHECKSUM_EN
    , CHK
`endif
  } state_t;
  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sclk_s_q, sclk_s_d, mosi_s_q, mosi_s_d, ss_s_q, ss_s_d;
  logic                   sclk_last_q, sclk_last_d, ss_last_q, ss_last_d;
  logic [3:0]             bit_cnt_q, bit_cnt_d;
  logic [0:7]             sh_q, sh_d, spi_in_q, spi_in_d;
  logic [6:0]             byte_cnt_q, byte_cnt_d;
  logic                   write_q, write_d, image_ready_q, image_ready_d, frame_err_q, frame_err_d;
`ifdef CHECKSUM_EN
  logic [7:0]             sum_q, sum_d;
`endif
  logic                   sclk_v, mosi_v, ss_v, rise, ss_fall, bit_done, take, full;
  assign sclk_v   = sclk_s_q[SYNC_STAGES-1];
  assign mosi_v   = mosi_s_q[SYNC_STAGES-1];
  assign ss_v     = ss_s_q[SYNC_STAGES-1];
  assign rise     = sclk_v & ~sclk_last_q;
  assign ss_fall  = ss_last_q & ~ss_v;
  assign bit_done = bit_cnt_q == 4'd8;
  // The 8th bit is still taken when ss_n rises alongside it, so that byte is written.
  assign take     = rise & ((bit_cnt_q == 4'd7) | ~ss_v);
  assign full     = byte_cnt_q == 7'(NUM_BYTES - 1);
  always_comb begin
    sclk_s_d      = {sclk_s_q[SYNC_STAGES-2:0], bus.sclk};
    mosi_s_d      = {mosi_s_q[SYNC_STAGES-2:0], bus.mosi};
    ss_s_d        = {ss_s_q[SYNC_STAGES-2:0], bus.ss_n};
    sclk_last_d   = sclk_v;
    ss_last_d     = ss_v;
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    sh_d          = take ? {sh_q[1:7], mosi_v} : sh_q;
    spi_in_d      = spi_in_q;
    write_d       = 1'b0;
    byte_cnt_d    = byte_cnt_q;
    image_ready_d = image_ready_q;
    frame_err_d   = frame_err_q;
`ifdef CHECKSUM_EN
    sum_d         = sum_q;
`endif
    case (state_q)
      IDLE: if (ss_fall) begin
        state_d       = RECV;
        bit_cnt_d     = '0;
        byte_cnt_d    = '0;
        image_ready_d = 1'b0;
        frame_err_d   = 1'b0;
`ifdef CHECKSUM_EN
        sum_d         = '0;
`endif
      end
      RECV: if (bit_done) begin
        state_d   = WRITE;
        bit_cnt_d = '0;
        spi_in_d  = sh_q;
        write_d   = 1'b1;
      end else if (take) begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (ss_v) begin
        state_d       = IDLE;
        frame_err_d   = 1'b1;
        image_ready_d = 1'b0;
      end
      WRITE: begin
        byte_cnt_d = byte_cnt_q + 7'd1;
`ifdef CHECKSUM_EN
        sum_d       = sum_q + spi_in_q;
        state_d     = ss_v ? IDLE : full ? CHK : RECV;
        frame_err_d = frame_err_q | ss_v;
`else
        state_d       = ss_v ? IDLE : full ? DONE : RECV;
        image_ready_d = image_ready_q | full;
        frame_err_d   = frame_err_q | (ss_v & ~full);
`endif
      end
`ifdef CHECKSUM_EN
      CHK: if (bit_done) begin
        state_d       = DONE;
        bit_cnt_d     = '0;
        image_ready_d = sh_q == sum_q;
        frame_err_d   = sh_q != sum_q;
      end else if (take) begin
        bit_cnt_d = bit_cnt_q + 4'd1;
      end else if (ss_v) begin
        state_d       = IDLE;
        frame_err_d   = 1'b1;
        image_ready_d = 1'b0;
      end
`endif
      DONE: if (ss_v) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.load_ack) image_ready_d = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sclk_s_q      <= '0;
      mosi_s_q      <= '0;
      ss_s_q        <= '1;
      sclk_last_q   <= 1'b0;
      ss_last_q     <= 1'b1;
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      sh_q          <= '0;
      spi_in_q      <= '0;
      byte_cnt_q    <= '0;
      write_q       <= 1'b0;
      image_ready_q <= 1'b0;
      frame_err_q   <= 1'b0;
`ifdef CHECKSUM_EN
      sum_q         <= '0;
`endif
    end else begin
      sclk_s_q      <= sclk_s_d;
      mosi_s_q      <= mosi_s_d;
      ss_s_q        <= ss_s_d;
      sclk_last_q   <= sclk_last_d;
      ss_last_q     <= ss_last_d;
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      sh_q          <= sh_d;
      spi_in_q      <= spi_in_d;
      byte_cnt_q    <= byte_cnt_d;
      write_q       <= write_d;
      image_ready_q <= image_ready_d;
      frame_err_q   <= frame_err_d;
`ifdef CHECKSUM_EN
      sum_q         <= sum_d;
`endif
    end
  end
  assign bus.spi_in      = spi_in_q;
  assign bus.write_en    = write_q;
  assign bus.shift_SPI   = write_q;
  assign bus.image_ready = image_ready_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.byte_cnt    = byte_cnt_q;
endmodule

// File: tb/tb_spi_pixel_loader.sv
// tb_spi_pixel_loader: directed frame vectors and corner-case sequences for spi_pixel_loader
module tb_spi_pixel_loader;
  localparam int NUM = 72;
  typedef struct {
    int nbytes;
    int bits;
    int base;
    int step;
    int cs;
    int exp_pulses;
    int exp_cnt;
    int exp_ready;
    int exp_err;
  } vec_t;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         checks = 0;
  int         failures = 0;
  int         pulse_cnt = 0;
  int         dbl_cnt = 0;
  int         strobe_mis = 0;
  logic       prev_we = 1'b0;
  logic [7:0] cap [512];
  vec_t       vecs [$];
  spi_pixel_loader_if bus ();
  spi_pixel_loader dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (bus.write_en) begin
      if (pulse_cnt < 512) cap[pulse_cnt] <= bus.spi_in;
      pulse_cnt <= pulse_cnt + 1;
    end
    if (bus.write_en && prev_we) dbl_cnt <= dbl_cnt + 1;
    if (bus.write_en != bus.shift_SPI) strobe_mis <= strobe_mis + 1;
    prev_we <= bus.write_en;
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask
  function automatic int byte_val(input vec_t v, input int i);
`ifdef CHECKSUM_EN
    if (i == NUM) return v.cs;
`endif
    return (v.base + v.step * i) & 255;
  endfunction
  task automatic send_bits(input int b, input int n);
    for (int i = 0; i < n; i++) begin
      bus.mosi = b[7-i];
      tick(4);
      bus.sclk = 1'b1;
      tick(4);
      bus.sclk = 1'b0;
    end
  endtask
  task automatic run_frame(input vec_t v);
    bus.ss_n = 1'b0;
    tick(4);
    for (int i = 0; i < v.nbytes; i++) send_bits(byte_val(v, i), 8);
    if (v.bits > 0) send_bits(byte_val(v, v.nbytes), v.bits);
    tick(4);
    bus.ss_n = 1'b1;
    tick(8);
  endtask
  task automatic check_frame(input vec_t v, input int k, input int base);
    check($sformatf("v%0d_pulses", k), pulse_cnt - base, v.exp_pulses);
    check($sformatf("v%0d_byte_cnt", k), int'(bus.byte_cnt), v.exp_cnt);
    check($sformatf("v%0d_image_ready", k), int'(bus.image_ready), v.exp_ready);
    check($sformatf("v%0d_frame_err", k), int'(bus.frame_err), v.exp_err);
    for (int j = 0; j < v.exp_pulses && base + j < 512; j++)
      check($sformatf("v%0d_byte%0d", k, j), int'(cap[base+j]), byte_val(v, j));
  endtask
  initial begin
    int base;
    bus.sclk = 1'b0;
    bus.mosi = 1'b0;
    bus.ss_n = 1'b1;
    bus.load_ack = 1'b0;
`ifdef CHECKSUM_EN
    vecs.push_back('{73, 0, 8'h00, 1, 8'hFC, 72, 72, 1, 0});
    vecs.push_back('{10, 3, 8'h30, 3, 0, 10, 10, 0, 1});
    vecs.push_back('{73, 0, 8'h01, 0, 8'h48, 72, 72, 1, 0});
    vecs.push_back('{73, 0, 8'h01, 0, 8'h47, 72, 72, 0, 1});
    vecs.push_back('{75, 0, 8'h01, 0, 8'h48, 72, 72, 1, 0});
    vecs.push_back('{72, 0, 8'h01, 0, 8'h48, 72, 72, 0, 1});
    vecs.push_back('{0, 5, 8'hFF, 0, 0, 0, 0, 0, 1});
`else
    vecs.push_back('{72, 0, 8'h00, 1, 0, 72, 72, 1, 0});
    vecs.push_back('{10, 3, 8'h30, 3, 0, 10, 10, 0, 1});
    vecs.push_back('{75, 0, 8'h80, 5, 0, 72, 72, 1, 0});
    vecs.push_back('{3, 0, 8'hA5, 0, 0, 3, 3, 0, 1});
    vecs.push_back('{0, 5, 8'hFF, 0, 0, 0, 0, 0, 1});
`endif
    tick(3);
    rst = 1'b0;
    check("rst_write_en", int'(bus.write_en), 0);
    check("rst_shift_SPI", int'(bus.shift_SPI), 0);
    check("rst_spi_in", int'(bus.spi_in), 0);
    check("rst_byte_cnt", int'(bus.byte_cnt), 0);
    check("rst_image_ready", int'(bus.image_ready), 0);
    check("rst_frame_err", int'(bus.frame_err), 0);
    for (int k = 0; k < vecs.size(); k++) begin
      base = pulse_cnt;
      run_frame(vecs[k]);
      check_frame(vecs[k], k, base);
    end
    base = pulse_cnt;
    bus.ss_n = 1'b0;
    tick(4);
    send_bits(8'hA5, 7);
    bus.mosi = 1'b1;
    tick(4);
    bus.sclk = 1'b1;
    tick(3);
    check("a5_we_early", int'(bus.write_en), 0);
    tick(1);
    check("a5_write_en", int'(bus.write_en), 1);
    check("a5_shift_SPI", int'(bus.shift_SPI), 1);
    check("a5_spi_in", int'(bus.spi_in), 8'hA5);
    tick(1);
    check("a5_we_after", int'(bus.write_en), 0);
    check("a5_spi_in_hold", int'(bus.spi_in), 8'hA5);
    tick(3);
    bus.sclk = 1'b0;
    tick(4);
    bus.ss_n = 1'b1;
    tick(8);
    check("a5_pulses", pulse_cnt - base, 1);
    check("a5_byte_cnt", int'(bus.byte_cnt), 1);
    check("a5_frame_err", int'(bus.frame_err), 1);
    base = pulse_cnt;
    run_frame(vecs[0]);
    check_frame(vecs[0], 90, base);
    bus.load_ack = 1'b1;
    tick(1);
    bus.load_ack = 1'b0;
    check("ack_image_ready", int'(bus.image_ready), 0);
    base = pulse_cnt;
    bus.ss_n = 1'b0;
    tick(4);
    for (int i = 0; i < 5; i++) send_bits(i, 8);
    send_bits(8'h05, 4);
    rst = 1'b1;
    bus.ss_n = 1'b1;
    tick(1);
    rst = 1'b0;
    check("mrst_write_en", int'(bus.write_en), 0);
    check("mrst_spi_in", int'(bus.spi_in), 0);
    check("mrst_byte_cnt", int'(bus.byte_cnt), 0);
    check("mrst_image_ready", int'(bus.image_ready), 0);
    check("mrst_frame_err", int'(bus.frame_err), 0);
    send_bits(8'hFF, 8);
    tick(8);
    check("mrst_pulses", pulse_cnt - base, 5);
    check("mrst_idle_byte_cnt", int'(bus.byte_cnt), 0);
    base = pulse_cnt;
    run_frame(vecs[0]);
    check_frame(vecs[0], 99, base);
    check("single_cycle_pulses", dbl_cnt, 0);
    check("strobes_match", strobe_mis, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
